// File: rtl/clock_control_card_pkg.sv
// Shared definitions for the clock control card: state encoding and default sizing.
package clock_control_card_pkg;

  localparam int DATAWIDTH_DEFAULT = 16;
  localparam int CTRLWIDTH_DEFAULT = 8;
  localparam int PHASES_DEFAULT    = 4;
  localparam int DEBOUNCE_DEFAULT  = 8;

  typedef enum logic [1:0] {
    CLKST_HALTED   = 2'd0,
    CLKST_RUNNING  = 2'd1,
    CLKST_STEPPING = 2'd2,
    CLKST_BREAK    = 2'd3
  } clk_state_t;

  // The CPU advances only in the two executing states.
  function automatic logic is_advancing(input clk_state_t s);
    return (s == CLKST_RUNNING) || (s == CLKST_STEPPING);
  endfunction

endpackage

// File: rtl/clock_control_card_debounce.sv
// Two-flop synchronizer plus saturating debounce counter producing one event per press.
module input_debounce #(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          meta_reg;
  logic          sync_reg;
  logic [CW-1:0] count_reg;
  logic          pulse_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg  <= 1'b0;
      sync_reg  <= 1'b0;
      count_reg <= '0;
      pulse_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      // Saturating at DEBOUNCE means a held button yields a single event.
      if (!sync_reg) begin
        count_reg <= '0;
        pulse_reg <= 1'b0;
      end else if (count_reg != CW'(DEBOUNCE)) begin
        count_reg <= count_reg + 1'b1;
        pulse_reg <= (count_reg == CW'(DEBOUNCE - 1));
      end else begin
        pulse_reg <= 1'b0;
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/clock_control_card.sv
// Instruction-granular clock enable and phase generator with run/halt, single step and breakpoint.
module clock_control_card
  import clock_control_card_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
  parameter int CTRLWIDTH = CTRLWIDTH_DEFAULT,
  parameter int PHASES    = PHASES_DEFAULT,
  parameter int DEBOUNCE  = DEBOUNCE_DEFAULT,
  localparam int PW       = $clog2(PHASES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] data,
  input  logic [DATAWIDTH-1:0] address,
  input  logic [CTRLWIDTH-1:0] ctrl,
  input  logic                 run_sw,
  input  logic                 step_btn,
  input  logic                 bp_en,
  input  logic [DATAWIDTH-1:0] bp_addr,
  output logic                 clk_en,
  output logic [PW-1:0]        phase,
  output logic                 running,
  output logic                 bp_hit
);

  clk_state_t    state_reg;
  logic [PW-1:0] phase_reg;
  logic          run_meta_reg;
  logic          run_s_reg;
  logic          run_armed_reg;
  logic          step_ev;
  logic          boundary;
  logic          unused_bus;

  assign unused_bus = ^{data, ctrl};

  input_debounce #(.DEBOUNCE(DEBOUNCE)) u_step (
    .clk   (clk),
    .rst   (rst),
    .din   (step_btn),
    .pulse (step_ev)
  );

  assign boundary = (phase_reg == PW'(PHASES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLKST_HALTED;
      phase_reg     <= '0;
      run_meta_reg  <= 1'b0;
      run_s_reg     <= 1'b0;
      run_armed_reg <= 1'b1;
    end else begin
      run_meta_reg <= run_sw;
      run_s_reg    <= run_meta_reg;
      if (!run_s_reg) run_armed_reg <= 1'b1;

      case (state_reg)
        CLKST_HALTED: begin
          phase_reg <= '0;
          if (run_s_reg)    state_reg <= CLKST_RUNNING;
          else if (step_ev) state_reg <= CLKST_STEPPING;
        end
        CLKST_RUNNING: begin
          phase_reg <= boundary ? '0 : phase_reg + 1'b1;
          if (boundary) begin
            if (bp_en && (address == bp_addr)) begin
              state_reg     <= CLKST_BREAK;
              run_armed_reg <= 1'b0;
            end else if (!run_s_reg) begin
              state_reg <= CLKST_HALTED;
            end
          end
        end
        CLKST_STEPPING: begin
          phase_reg <= boundary ? '0 : phase_reg + 1'b1;
          if (boundary) state_reg <= CLKST_HALTED;
        end
        default: begin
          // BREAK: resuming requires the run switch to have been cycled since entry.
          phase_reg <= '0;
          if (step_ev)                         state_reg <= CLKST_STEPPING;
          else if (run_s_reg && run_armed_reg) state_reg <= CLKST_RUNNING;
        end
      endcase
    end
  end

  assign clk_en  = is_advancing(state_reg);
  assign running = (state_reg == CLKST_RUNNING);
  assign bp_hit  = (state_reg == CLKST_BREAK);
  assign phase   = phase_reg;

endmodule

// File: tb/tb_clock_control_card.sv
// Directed bench for clock_control_card: cycle-by-cycle expected outputs checked through a scoreboard queue.
module tb_clock_control_card;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic [DW-1:0] address;
  logic [CW-1:0] ctrl;
  logic          run_sw;
  logic          step_btn;
  logic          bp_en;
  logic [DW-1:0] bp_addr;
  logic          clk_en;
  logic [1:0]    phase;
  logic          running;
  logic          bp_hit;

  int            tests_run = 0;
  int            tests_failed = 0;
  int            cyc_n = 0;
  string         tag = "reset";
  logic [4:0]    exp_q[$];

  // Packed as {clk_en, phase, running, bp_hit}
  localparam logic [4:0] EXP_H = 5'b0_00_0_0;
  localparam logic [4:0] EXP_B = 5'b0_00_0_1;

  clock_control_card #(
    .DATAWIDTH(DW), .CTRLWIDTH(CW), .PHASES(4), .DEBOUNCE(8)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .address(address), .ctrl(ctrl),
    .run_sw(run_sw), .step_btn(step_btn), .bp_en(bp_en), .bp_addr(bp_addr),
    .clk_en(clk_en), .phase(phase), .running(running), .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] exp_r(input int p);
    logic [1:0] pp;
    pp = 2'(p);
    return {1'b1, pp, 1'b1, 1'b0};
  endfunction

  function automatic logic [4:0] exp_s(input int p);
    logic [1:0] pp;
    pp = 2'(p);
    return {1'b1, pp, 1'b0, 1'b0};
  endfunction

  // Apply the current inputs at the next rising edge, then check outputs at the falling edge.
  task automatic cyc(input logic [4:0] e);
    logic [4:0] obs;
    logic [4:0] expv;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    obs  = {clk_en, phase, running, bp_hit};
    expv = exp_q.pop_front();
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s cycle %0d: observed {en,ph,run,bp}=%b expected %b", tag, cyc_n, obs, expv);
    end
    $display("[TB] %s cycle %0d: en=%b phase=%0d running=%b bp_hit=%b", tag, cyc_n,
             clk_en, phase, running, bp_hit);
  endtask

  task automatic cyc_n_times(input int n, input logic [4:0] e);
    for (int i = 0; i < n; i++) cyc(e);
  endtask

  initial begin
    rst = 1'b1; data = '0; address = '0; ctrl = '0;
    run_sw = 1'b0; step_btn = 1'b0; bp_en = 1'b0; bp_addr = '0;
    cyc(EXP_H);
    cyc(EXP_H);
    rst = 1'b0;
    cyc(EXP_H);

    tag = "run_start";
    run_sw = 1'b1;
    cyc(EXP_H); cyc(EXP_H);
    cyc(exp_r(0)); cyc(exp_r(1)); cyc(exp_r(2)); cyc(exp_r(3)); cyc(exp_r(0)); cyc(exp_r(1));

    tag = "run_stop";
    run_sw = 1'b0;
    cyc(exp_r(2)); cyc(exp_r(3)); cyc(EXP_H); cyc(EXP_H);

    tag = "step_bounce";
    step_btn = 1'b1; cyc(EXP_H);
    step_btn = 1'b0; cyc(EXP_H);
    step_btn = 1'b1;
    cyc_n_times(10, EXP_H);
    cyc(exp_s(0)); cyc(exp_s(1)); cyc(exp_s(2)); cyc(exp_s(3));
    cyc_n_times(8, EXP_H);
    tag = "step_release";
    step_btn = 1'b0;
    cyc_n_times(3, EXP_H);
    tag = "step_second";
    step_btn = 1'b1;
    cyc_n_times(10, EXP_H);
    cyc(exp_s(0)); cyc(exp_s(1)); cyc(exp_s(2)); cyc(exp_s(3));
    cyc_n_times(3, EXP_H);
    step_btn = 1'b0;
    cyc_n_times(3, EXP_H);

    tag = "bp_hit";
    bp_en = 1'b1; bp_addr = 16'h000C; address = 16'h000C;
    run_sw = 1'b1;
    cyc(EXP_H); cyc(EXP_H);
    cyc(exp_r(0)); cyc(exp_r(1)); cyc(exp_r(2)); cyc(exp_r(3));
    cyc(EXP_B);
    tag = "bp_no_resume";
    cyc_n_times(5, EXP_B);
    tag = "bp_rearm";
    run_sw = 1'b0;
    cyc_n_times(3, EXP_B);
    run_sw = 1'b1;
    cyc(EXP_B); cyc(EXP_B);
    cyc(exp_r(0)); cyc(exp_r(1)); cyc(exp_r(2)); cyc(exp_r(3));
    cyc(EXP_B);
    tag = "bp_step";
    run_sw = 1'b0; step_btn = 1'b1;
    cyc_n_times(10, EXP_B);
    cyc(exp_s(0)); cyc(exp_s(1)); cyc(exp_s(2)); cyc(exp_s(3));
    cyc(EXP_H); cyc(EXP_H);
    step_btn = 1'b0;
    cyc_n_times(3, EXP_H);

    tag = "run_step_race";
    bp_en = 1'b0;
    step_btn = 1'b1;
    cyc_n_times(8, EXP_H);
    run_sw = 1'b1;
    cyc(EXP_H); cyc(EXP_H);
    cyc(exp_r(0)); cyc(exp_r(1)); cyc(exp_r(2)); cyc(exp_r(3)); cyc(exp_r(0));
    tag = "race_halt";
    run_sw = 1'b0;
    cyc(exp_r(1)); cyc(exp_r(2)); cyc(exp_r(3));
    cyc_n_times(4, EXP_H);
    step_btn = 1'b0;
    cyc_n_times(4, EXP_H);

    tag = "reset_mid";
    run_sw = 1'b1;
    cyc(EXP_H); cyc(EXP_H);
    cyc(exp_r(0)); cyc(exp_r(1)); cyc(exp_r(2));
    rst = 1'b1;
    cyc(EXP_H);
    rst = 1'b0;
    cyc(EXP_H); cyc(EXP_H);
    cyc(exp_r(0)); cyc(exp_r(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
